// File: rtl/serial_adder_pkg.sv
// Shared constants and helpers for the bit-serial adder slice.
// Holds the default operand width and the counter width rule.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder built from two half adders and an OR.
// Shared by the serial adder and later ripple adders.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic sum,
  output logic carry
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (
    .a     (A),
    .b     (B),
    .sum   (s1),
    .carry (c1)
  );

  half_adder u_ha1 (
    .a     (s1),
    .b     (Cin),
    .sum   (sum),
    .carry (c2)
  );

  assign carry = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Half-adder primitive: sum and carry of two bits.
// Leaf cell reused by the full-adder and wider arithmetic.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB first, one bit per clock through one
// full-adder cell, with a start/busy/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             c_reg;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] s_next;

  full_adder u_fa (
    .A     (a_sh[0]),
    .B     (b_sh[0]),
    .Cin   (c_reg),
    .sum   (fa_s),
    .carry (fa_c)
  );

  assign s_next = {fa_s, s_sh[WIDTH-1:1]};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // IDLE, DONE and the unreachable code all accept a new start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      c_reg <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          s_sh  <= s_next;
          c_reg <= fa_c;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
            sum   <= s_next;
            carry <= fa_c;
          end
        end
        default: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            c_reg <= cin;
            cnt   <= CW'(WIDTH);
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8.
// Cycle model plus directed literal checks.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  int tests = 0;
  int fails = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  always #5 clk = ~clk;

  // model: an accepted operation is busy for W cycles, then done
  bit       m_busy = 0;
  bit       m_done = 0;
  int       m_left = 0;
  bit [W:0] m_pend = '0;
  bit [W:0] m_res  = '0;

  always @(negedge rst_n) begin
    m_busy = 0;
    m_done = 0;
    m_left = 0;
    m_res  = '0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_done = 1;
          m_res  = m_pend;
        end
      end else begin
        m_done = 0;
        if (start) begin
          m_pend = {1'b0, A} + {1'b0, B} + (W+1)'(cin);
          m_busy = 1;
          m_left = W;
        end
      end
    end
  end

  task automatic check(input string name, input logic [W:0] got,
                       input logic [W:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp,
               $time);
    end
  endtask

  int cyc = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    check("cyc_busy", {8'h0, busy}, {8'h0, m_busy});
    check("cyc_done", {8'h0, done}, {8'h0, m_done});
    check("cyc_result", {carry, sum}, m_res);
  end

  task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic c);
    @(negedge clk); #1;
    A = a; B = b; cin = c; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk); #1;
      if (done) seen = 1;
    end
    if (!seen) check({name, "_timeout"}, 9'h0, 9'h1);
  endtask

  int t0;
  int t1;
  int t2;

  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      start = 1'($urandom); A = W'($urandom); B = W'($urandom);
      cin = 1'($urandom);
      check("rst_out", {carry, sum}, 9'h000);
      check("rst_bd", {7'h0, busy, done}, 9'h0);
    end
    @(negedge clk); #1;
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #1;

    busy_cnt = 0;
    done_cnt = 0;
    pulse_start(8'h35, 8'h4A, 1'b0);
    wait_done("t35");
    check("t35_sum", {carry, sum}, 9'h07F);
    check("t35_busy_cycles", 9'(busy_cnt), 9'd8);
    @(negedge clk); #1;
    check("t35_done_once", 9'(done_cnt), 9'd1);

    pulse_start(8'hFF, 8'h01, 1'b0);
    wait_done("tff01");
    check("tff01_sum", {carry, sum}, 9'h100);
    pulse_start(8'hFF, 8'hFF, 1'b1);
    wait_done("tffff");
    check("tffff_sum", {carry, sum}, 9'h1FF);
    @(negedge clk); #1;

    done_cnt = 0;
    pulse_start(8'h10, 8'h20, 1'b0);
    @(negedge clk); #1;
    A = 8'hAA; B = 8'h55; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    check("ign_run_sum", {carry, sum}, 9'h1FF);
    wait_done("ign");
    check("ign_sum", {carry, sum}, 9'h030);
    repeat (6) @(negedge clk);
    #1;
    check("ign_done_once", 9'(done_cnt), 9'd1);

    @(negedge clk); #1;
    A = 8'h01; B = 8'h02; cin = 1'b1; start = 1'b1;
    wait_done("bb0");
    t0 = cyc;
    check("bb0_sum", {carry, sum}, 9'h004);
    wait_done("bb1");
    t1 = cyc;
    check("bb1_sum", {carry, sum}, 9'h004);
    wait_done("bb2");
    t2 = cyc;
    check("bb_gap1", 9'(t1 - t0), 9'd9);
    check("bb_gap2", 9'(t2 - t1), 9'd9);
    start = 1'b0;
    @(negedge clk); #1;
    check("bb_stop", {7'h0, busy, done}, 9'h0);

    done_cnt = 0;
    pulse_start(8'hF0, 8'h0F, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", {carry, sum}, 9'h000);
    check("mid_rst_bd", {7'h0, busy, done}, 9'h0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("mid_rst_no_done", 9'(done_cnt), 9'd0);
    pulse_start(8'h80, 8'h80, 1'b0);
    wait_done("t8080");
    check("t8080_sum", {carry, sum}, 9'h100);
    repeat (3) @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
